// File: rtl/wb_grf_if.sv
// ---------------------------------------------------------------------------
// wb_grf_if : MEM/WB inputs, ID read ports and forwarding outputs of wb_grf
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_grf_if;
   logic        RegWrite_wb;
   logic [1:0]  MemtoReg_wb;
   logic [31:0] dmout_wb;
   logic [31:0] aluout_wb;
   logic [31:0] pc_wb;
   logic [4:0]  a3_wb;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] wd_wb;
   logic        we_eff;
   logic [31:0] wb_count;

   modport master (
      output RegWrite_wb, MemtoReg_wb, dmout_wb, aluout_wb, pc_wb, a3_wb, a1, a2,
      input  rd1, rd2, wd_wb, we_eff, wb_count
   );

   modport slave (
      input  RegWrite_wb, MemtoReg_wb, dmout_wb, aluout_wb, pc_wb, a3_wb, a1, a2,
      output rd1, rd2, wd_wb, we_eff, wb_count
   );
endinterface

`default_nettype wire

// File: rtl/wb_grf.sv
// ---------------------------------------------------------------------------
// wb_grf : MIPS write-back mux and 32x32 register file with two read ports.
// Optional macro WB_GRF_BYPASS_EN forwards the write-back value to the reads.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_grf (
   input  logic     clk,
   input  logic     rst_n,
   wb_grf_if.slave  bus
);

   logic [31:0] regs [32];
   logic [31:0] count;
   logic [31:0] wd;
   logic        we;
   logic [4:0]  raddr [2];
   logic [31:0] rdata [2];

   always_comb begin
      case (bus.MemtoReg_wb)
         2'b01:   wd = bus.dmout_wb;
         2'b10:   wd = bus.pc_wb + 32'd8;
         default: wd = bus.aluout_wb;
      endcase
   end

   assign we           = bus.RegWrite_wb && (bus.a3_wb != 5'd0);
   assign bus.wd_wb    = wd;
   assign bus.we_eff   = we;
   assign bus.wb_count = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
         count <= 32'd0;
      end else if (we) begin
         regs[bus.a3_wb] <= wd;
         count           <= count + 32'd1;
      end
   end

   assign raddr[0] = bus.a1;
   assign raddr[1] = bus.a2;

   genvar p;
   generate
      for (p = 0; p < 2; p++) begin : g_rd
         always_comb begin
            rdata[p] = regs[raddr[p]];
`ifdef WB_GRF_BYPASS_EN
            if (we && (raddr[p] == bus.a3_wb)) begin
               rdata[p] = wd;
            end
`endif
            // $0 is hard-wired to zero even when bypassing
            if (raddr[p] == 5'd0) begin
               rdata[p] = 32'd0;
            end
         end
      end
   endgenerate

   assign bus.rd1 = rdata[0];
   assign bus.rd2 = rdata[1];

endmodule

`default_nettype wire

// File: tb/tb_wb_grf.sv
// ---------------------------------------------------------------------------
// tb_wb_grf : directed plus randomized self-checking bench for wb_grf
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_grf;

   logic clk;
   logic rst_n;
   int   vectors;
   int   fails;
   bit   run_cmp;

   logic [31:0] model_regs [32];
   logic [31:0] model_count;

   wb_grf_if bus ();

   wb_grf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: register contents as an array, count of non-$0 writes
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
         model_count <= 32'd0;
      end else if (bus.RegWrite_wb && bus.a3_wb != 5'd0) begin
         model_regs[bus.a3_wb] <= exp_wd();
         model_count           <= model_count + 32'd1;
      end
   end

   function automatic logic [31:0] exp_wd();
      if (bus.MemtoReg_wb == 2'b01) return bus.dmout_wb;
      if (bus.MemtoReg_wb == 2'b10) return bus.pc_wb + 32'd8;
      return bus.aluout_wb;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef WB_GRF_BYPASS_EN
      if (bus.RegWrite_wb && a == bus.a3_wb) return exp_wd();
`endif
      return model_regs[a];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_cmp) begin
         check("rd1",      bus.rd1,      exp_rd(bus.a1));
         check("rd2",      bus.rd2,      exp_rd(bus.a2));
         check("wd_wb",    bus.wd_wb,    exp_wd());
         check("we_eff",   {31'd0, bus.we_eff}, {31'd0, bus.RegWrite_wb && bus.a3_wb != 5'd0});
         check("wb_count", bus.wb_count, model_count);
      end
   end

   task automatic drive(input logic we, input logic [1:0] sel, input logic [31:0] dm,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] a3, input logic [4:0] ra1, input logic [4:0] ra2);
      @(posedge clk);
      #1;
      bus.RegWrite_wb = we;
      bus.MemtoReg_wb = sel;
      bus.dmout_wb    = dm;
      bus.aluout_wb   = alu;
      bus.pc_wb       = pc;
      bus.a3_wb       = a3;
      bus.a1          = ra1;
      bus.a2          = ra2;
   endtask

   task automatic peek();
      @(negedge clk);
      #1;
   endtask

   initial begin
      vectors = 0;
      fails   = 0;
      run_cmp = 1'b0;
      rst_n   = 1'b0;
      bus.RegWrite_wb = 1'b0;
      bus.MemtoReg_wb = 2'b00;
      bus.dmout_wb    = 32'd0;
      bus.aluout_wb   = 32'd0;
      bus.pc_wb       = 32'd0;
      bus.a3_wb       = 5'd0;
      bus.a1          = 5'd0;
      bus.a2          = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      run_cmp = 1'b1;

      // Reset state and $0 protection
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
      peek();
      check("reset_rd1", bus.rd1, 32'd0);
      check("reset_rd2", bus.rd2, 32'd0);
      check("reset_count", bus.wb_count, 32'd0);
      drive(1'b1, 2'b00, 32'd0, 32'hDEADBEEF, 32'd0, 5'd0, 5'd0, 5'd0);
      peek();
      check("r0_we_eff", {31'd0, bus.we_eff}, 32'd0);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      peek();
      check("r0_read", bus.rd1, 32'd0);
      check("r0_count", bus.wb_count, 32'd0);

      // Each write-back source
      drive(1'b1, 2'b00, 32'd0, 32'h12345678, 32'd0, 5'd8, 5'd0, 5'd0);
      drive(1'b1, 2'b01, 32'hCAFEF00D, 32'd0, 32'd0, 5'd9, 5'd0, 5'd0);
      drive(1'b1, 2'b10, 32'd0, 32'd0, 32'h00003000, 5'd31, 5'd0, 5'd0);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd9);
      peek();
      check("mux_alu", bus.rd1, 32'h12345678);
      check("mux_mem", bus.rd2, 32'hCAFEF00D);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd31);
      peek();
      check("mux_link", bus.rd1, 32'h00003008);
      check("mux_count", bus.wb_count, 32'd3);

      // Link value wraps modulo 2^32
      drive(1'b1, 2'b10, 32'd0, 32'd0, 32'hFFFFFFFC, 5'd31, 5'd0, 5'd0);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd0);
      peek();
      check("link_wrap", bus.rd1, 32'h00000004);

      // Same-cycle read and write of $10
      drive(1'b1, 2'b00, 32'd0, 32'd1, 32'd0, 5'd10, 5'd0, 5'd0);
      drive(1'b1, 2'b00, 32'd0, 32'd2, 32'd0, 5'd10, 5'd10, 5'd0);
      peek();
`ifdef WB_GRF_BYPASS_EN
      check("same_cycle_before", bus.rd1, 32'd2);
`else
      check("same_cycle_before", bus.rd1, 32'd1);
`endif
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd10, 5'd0);
      peek();
      check("same_cycle_after", bus.rd1, 32'd2);

      // Disabled write
      drive(1'b0, 2'b00, 32'd0, 32'd7, 32'd0, 5'd12, 5'd12, 5'd0);
      peek();
      check("dis_we_eff", {31'd0, bus.we_eff}, 32'd0);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd12, 5'd0);
      peek();
      check("dis_reg", bus.rd1, 32'd0);
      check("dis_count", bus.wb_count, 32'd6);

      // Asynchronous reset mid-operation
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 2'b00, 32'd0, 32'h11, 32'd0, 5'd1, 5'd0, 5'd0);
      drive(1'b1, 2'b00, 32'd0, 32'h22, 32'd0, 5'd2, 5'd0, 5'd0);
      drive(1'b1, 2'b00, 32'd0, 32'h33, 32'd0, 5'd3, 5'd0, 5'd0);
      drive(1'b1, 2'b00, 32'd0, 32'h55, 32'd0, 5'd5, 5'd0, 5'd0);
      drive(1'b1, 2'b00, 32'd0, 32'hA5A5A5A5, 32'd0, 5'd4, 5'd0, 5'd0);
      drive(1'b1, 2'b00, 32'd0, 32'h66, 32'd0, 5'd6, 5'd4, 5'd6);
      peek();
      check("pre_rst_reg", bus.rd1, 32'hA5A5A5A5);
      check("pre_rst_count", bus.wb_count, 32'd5);
      rst_n = 1'b0;
      #1;
      check("rst_async_reg", bus.rd1, 32'd0);
      check("rst_async_count", bus.wb_count, 32'd0);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd6);
      rst_n = 1'b1;
      peek();
      check("rst_lost_write", bus.rd2, 32'd0);
      check("rst_after_count", bus.wb_count, 32'd0);

      // Randomized traffic with occasional asynchronous reset pulses
      for (int n = 0; n < 600; n++) begin
         logic [4:0] a3;
         a3 = 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
               $urandom, a3,
               ($urandom_range(0, 1) == 1) ? a3 : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31)));
         rst_n = 1'b1;
         if ($urandom_range(0, 49) == 0) begin
            #6;
            rst_n = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      peek();
      run_cmp = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

`default_nettype wire
